// File: rtl/popcount_expander.sv
// Expands a ones count into a WIDTH-bit serial thermometer word: count ones first, then zeros.
// One word per WIDTH cycles at full throughput; the next count is accepted on the last beat.
//
// state | meaning
// IDLE  | no word in flight, ready for a count
// SEND  | emitting beat r_idx of the current word
module popcount_expander #(
  parameter  int WIDTH = 8,
  localparam int CNTW  = $clog2(WIDTH) + 2
) (
  input  logic            clk_i,
  input  logic            srst_i,
  input  logic            data_val_i,
  input  logic [CNTW-1:0] data_i,
  output logic            ready_o,
  output logic            ser_data_o,
  output logic            ser_val_o,
  output logic            start_o,
  output logic            last_o,
  output logic            ovf_o
);

  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0]   LAST_IDX = IW'(WIDTH - 1);
  localparam logic [CNTW-1:0] MAX_CNT  = CNTW'(WIDTH);

  typedef enum logic {IDLE, SEND} state_t;

  state_t          r_state;
  logic [IW-1:0]   r_idx;
  logic [CNTW-1:0] r_cnt;
  logic            r_ovf;
  logic            r_ser_data;
  logic            r_ser_val;
  logic            r_start;
  logic            r_last;
  logic            r_ovf_pulse;

  state_t          w_state_nxt;
  logic [IW-1:0]   w_idx_nxt;
  logic [CNTW-1:0] w_cnt_nxt;
  logic            w_ovf_nxt;
  logic            w_last_beat;
  logic            w_accept;
  logic            w_over;
  logic [CNTW-1:0] w_clamped;

  assign w_last_beat = (r_state == SEND) && (r_idx == LAST_IDX);
  // Ready must drop during reset even though the state register has not cleared yet.
  assign ready_o     = !srst_i && ((r_state == IDLE) || w_last_beat);
  assign w_accept    = data_val_i && ready_o;
  assign w_over      = (data_i > MAX_CNT);
  assign w_clamped   = w_over ? MAX_CNT : data_i;

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    w_ovf_nxt   = r_ovf;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = SEND;
          w_idx_nxt   = '0;
          w_cnt_nxt   = w_clamped;
          w_ovf_nxt   = w_over;
        end
      end
      SEND: begin
        if (w_last_beat) begin
          w_idx_nxt = '0;
          if (w_accept) begin
            w_cnt_nxt = w_clamped;
            w_ovf_nxt = w_over;
          end else begin
            w_state_nxt = IDLE;
          end
        end else begin
          w_idx_nxt = r_idx + 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_idx_nxt   = '0;
      end
    endcase
  end

  // Output beats are decoded from the next-state values so they are true flops.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
      r_ser_data  <= 1'b0;
      r_ser_val   <= 1'b0;
      r_start     <= 1'b0;
      r_last      <= 1'b0;
      r_ovf_pulse <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_cnt       <= w_cnt_nxt;
      r_ovf       <= w_ovf_nxt;
      r_ser_val   <= (w_state_nxt == SEND);
      r_ser_data  <= (w_state_nxt == SEND) && (CNTW'(w_idx_nxt) < w_cnt_nxt);
      r_start     <= (w_state_nxt == SEND) && (w_idx_nxt == '0);
      r_last      <= (w_state_nxt == SEND) && (w_idx_nxt == LAST_IDX);
      r_ovf_pulse <= (w_state_nxt == SEND) && w_ovf_nxt && (w_idx_nxt == '0);
    end
  end

  assign ser_data_o = r_ser_data;
  assign ser_val_o  = r_ser_val;
  assign start_o    = r_start;
  assign last_o     = r_last;
  assign ovf_o      = r_ovf_pulse;

endmodule
